// File: rtl/braid_mix_scheduler.sv
// Load / mix / flush sequencer for the 8x4 mixer braid; owns every valve, pump and column line.
// Optional multi-pass recirculation is enabled by defining BRAID_SCHED_RECIRC_EN.
module braid_mix_scheduler #(
    parameter int ROWS         = 8,
    parameter int STAGES       = 4,
    parameter int LOAD_CYCLES  = 4,
    parameter int MIX_CYCLES   = 8,
    parameter int FLUSH_CYCLES = 6,
    localparam int IW          = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef BRAID_SCHED_RECIRC_EN
    input  logic [1:0]        passes_i,
`endif
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ROWS-1:0]   input_mask_i,
    output logic [ROWS-1:0]   load_valve_o,
    output logic [STAGES-1:0] stage_en_o,
    output logic              pump_en_o,
    output logic              flush_valve_o,
    output logic [IW-1:0]     stage_idx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic              error_o
);

    // state   | meaning
    // S_IDLE  | all actuation off, waiting for start
    // S_LOAD  | inlet valves open on latched mask, pump on
    // S_MIX   | one mixer column actuated at a time
    // S_FLUSH | outlet valve open, pump on
    // S_DONE  | one-cycle completion report
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MIX   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [15:0]       LOAD_M1    = 16'(LOAD_CYCLES - 1);
    localparam logic [15:0]       MIX_M1     = 16'(MIX_CYCLES - 1);
    localparam logic [15:0]       FLUSH_M1   = 16'(FLUSH_CYCLES - 1);
    localparam logic [IW-1:0]     LAST_STAGE = IW'(STAGES - 1);
    localparam logic [STAGES-1:0] STAGE_ONE  = STAGES'(1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [IW-1:0]     stage_q, stage_d;
    logic [ROWS-1:0]   mask_q, mask_d;
    logic              abt_q, abt_d;
    logic              err_d;
    logic              last_pass;

`ifdef BRAID_SCHED_RECIRC_EN
    logic [1:0]        passes_q, passes_d;
    logic [1:0]        pass_q, pass_d;
    assign last_pass = (pass_q == passes_q);
`else
    assign last_pass = 1'b1;
`endif

    logic [ROWS-1:0]   load_valve_d;
    logic [STAGES-1:0] stage_en_d;
    logic              pump_en_d;
    logic              flush_valve_d;
    logic [IW-1:0]     stage_idx_d;
    logic              busy_d;
    logic              done_d;
    logic              aborted_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        mask_d   = mask_q;
        abt_d    = abt_q;
        err_d    = 1'b0;
`ifdef BRAID_SCHED_RECIRC_EN
        passes_d = passes_q;
        pass_d   = pass_q;
`endif
        case (state_q)
            S_IDLE: begin
                // abort held together with start suppresses both the run and the error
                if (start_i && !abort_i) begin
                    if (input_mask_i != '0) begin
                        state_d  = S_LOAD;
                        mask_d   = input_mask_i;
                        cnt_d    = LOAD_M1;
                        stage_d  = '0;
                        abt_d    = 1'b0;
`ifdef BRAID_SCHED_RECIRC_EN
                        passes_d = passes_i;
                        pass_d   = 2'd0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_M1;
                    abt_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_MIX;
                    cnt_d   = MIX_M1;
                    stage_d = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_MIX: begin
                if (abort_i) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_M1;
                    stage_d = '0;
                    abt_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    if (stage_q != LAST_STAGE) begin
                        stage_d = stage_q + IW'(1);
                        cnt_d   = MIX_M1;
                    end else if (last_pass) begin
                        state_d = S_FLUSH;
                        cnt_d   = FLUSH_M1;
                        stage_d = '0;
                    end else begin
`ifdef BRAID_SCHED_RECIRC_EN
                        pass_d  = pass_q + 2'd1;
`endif
                        stage_d = '0;
                        cnt_d   = MIX_M1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                mask_d  = '0;
                abt_d   = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and flopped, so every actuation line is glitch-free
    always_comb begin
        load_valve_d  = (state_d == S_LOAD) ? mask_d : '0;
        stage_en_d    = (state_d == S_MIX) ? (STAGE_ONE << stage_d) : '0;
        stage_idx_d   = (state_d == S_MIX) ? stage_d : '0;
        pump_en_d     = (state_d == S_LOAD) || (state_d == S_FLUSH);
        flush_valve_d = (state_d == S_FLUSH);
        busy_d        = (state_d == S_LOAD) || (state_d == S_MIX) || (state_d == S_FLUSH);
        done_d        = (state_d == S_DONE);
        aborted_d     = (state_d == S_DONE) && abt_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            stage_q       <= '0;
            mask_q        <= '0;
            abt_q         <= 1'b0;
`ifdef BRAID_SCHED_RECIRC_EN
            passes_q      <= '0;
            pass_q        <= '0;
`endif
            load_valve_o  <= '0;
            stage_en_o    <= '0;
            stage_idx_o   <= '0;
            pump_en_o     <= 1'b0;
            flush_valve_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            aborted_o     <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stage_q       <= stage_d;
            mask_q        <= mask_d;
            abt_q         <= abt_d;
`ifdef BRAID_SCHED_RECIRC_EN
            passes_q      <= passes_d;
            pass_q        <= pass_d;
`endif
            load_valve_o  <= load_valve_d;
            stage_en_o    <= stage_en_d;
            stage_idx_o   <= stage_idx_d;
            pump_en_o     <= pump_en_d;
            flush_valve_o <= flush_valve_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
            aborted_o     <= aborted_d;
            error_o       <= err_d;
        end
    end

endmodule

// File: tb/tb_braid_mix_scheduler.sv
// Scoreboard bench for braid_mix_scheduler: per-cycle expected output records are queued with
// each stimulus and compared at the falling edge; define BRAID_SCHED_RECIRC_EN to add the recirc run.
module tb_braid_mix_scheduler;

    typedef struct packed {
        logic [7:0] lv;
        logic [3:0] se;
        logic       pump;
        logic       flush;
        logic [1:0] idx;
        logic       busy;
        logic       done;
        logic       ab;
        logic       err;
    } out_t;

    bit         clk_i;
    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic [7:0] input_mask_i;
`ifdef BRAID_SCHED_RECIRC_EN
    logic [1:0] passes_i;
`endif
    logic [7:0] load_valve_o;
    logic [3:0] stage_en_o;
    logic       pump_en_o;
    logic       flush_valve_o;
    logic [1:0] stage_idx_o;
    logic       busy_o;
    logic       done_o;
    logic       aborted_o;
    logic       error_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   busy_cnt;
    out_t exp_q[$];

    braid_mix_scheduler dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
`ifdef BRAID_SCHED_RECIRC_EN
        .passes_i     (passes_i),
`endif
        .start_i      (start_i),
        .abort_i      (abort_i),
        .input_mask_i (input_mask_i),
        .load_valve_o (load_valve_o),
        .stage_en_o   (stage_en_o),
        .pump_en_o    (pump_en_o),
        .flush_valve_o(flush_valve_o),
        .stage_idx_o  (stage_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .aborted_o    (aborted_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic out_t r_idle();
        out_t o = '0;
        return o;
    endfunction

    function automatic out_t r_load(input logic [7:0] m);
        out_t o = '0;
        o.lv = m; o.pump = 1'b1; o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t r_mix(input int s);
        out_t o = '0;
        o.se = 4'(1 << s); o.idx = 2'(s); o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t r_flush();
        out_t o = '0;
        o.flush = 1'b1; o.pump = 1'b1; o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t r_done(input logic a);
        out_t o = '0;
        o.done = 1'b1; o.ab = a;
        return o;
    endfunction

    function automatic out_t r_err();
        out_t o = '0;
        o.err = 1'b1;
        return o;
    endfunction

    task automatic push_n(input out_t r, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(r);
    endtask

    task automatic push_sweeps(input int nsweep);
        for (int p = 0; p < nsweep; p++)
            for (int s = 0; s < 4; s++)
                push_n(r_mix(s), 8);
    endtask

    task automatic tick(input string tag);
        out_t obs, e;
        int   act;
        @(negedge clk_i);
        obs = {load_valve_o, stage_en_o, pump_en_o, flush_valve_o, stage_idx_o,
               busy_o, done_o, aborted_o, error_o};
        if (busy_o === 1'b1) busy_cnt++;
        act = int'(load_valve_o != 8'h00) + int'(stage_en_o != 4'h0) + int'(flush_valve_o);
        if (act > 1) chk({tag, "_exclusive"}, 32'(act), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(obs), 32'(e));
        end
    endtask

    task automatic tick_n(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; input_mask_i = 8'h00;
`ifdef BRAID_SCHED_RECIRC_EN
        passes_i = 2'd0;
`endif
        push_n(r_idle(), 2);
        tick_n("reset", 2);
        rst_i = 1'b0;
        push_n(r_idle(), 1);
        tick("post_reset");

        // nominal run, then a start held during DONE that must be ignored
        start_i = 1'b1; input_mask_i = 8'hA5;
        push_n(r_load(8'hA5), 4);
        push_sweeps(1);
        push_n(r_flush(), 6);
        push_n(r_done(1'b0), 1);
        push_n(r_idle(), 2);
        tick("run_a5");
        start_i = 1'b0; input_mask_i = 8'h00;
        tick_n("run_a5", 42);
        start_i = 1'b1; input_mask_i = 8'hFF;
        tick("start_in_done");
        start_i = 1'b0; input_mask_i = 8'h00;
        tick("start_in_done");

        start_i = 1'b1; input_mask_i = 8'h00;
        push_n(r_err(), 1);
        push_n(r_idle(), 2);
        tick("zero_mask");
        start_i = 1'b0;
        tick_n("zero_mask", 2);

        // abort in the third cycle of column 2
        start_i = 1'b1; input_mask_i = 8'h3C;
        push_n(r_load(8'h3C), 4);
        push_n(r_mix(0), 8);
        push_n(r_mix(1), 8);
        push_n(r_mix(2), 3);
        push_n(r_flush(), 6);
        push_n(r_done(1'b1), 1);
        push_n(r_idle(), 1);
        tick("abort_mix");
        start_i = 1'b0;
        tick_n("abort_mix", 22);
        abort_i = 1'b1;
        tick("abort_mix");
        abort_i = 1'b0;
        tick_n("abort_mix", 7);

        start_i = 1'b1; input_mask_i = 8'h01;
        push_n(r_load(8'h01), 2);
        push_n(r_flush(), 6);
        push_n(r_done(1'b1), 1);
        push_n(r_idle(), 1);
        tick("abort_load");
        start_i = 1'b0;
        tick("abort_load");
        abort_i = 1'b1;
        tick("abort_load");
        abort_i = 1'b0;
        tick_n("abort_load", 7);

        // abort in FLUSH is ignored and does not flag the run
        start_i = 1'b1; input_mask_i = 8'h10;
        push_n(r_load(8'h10), 4);
        push_sweeps(1);
        push_n(r_flush(), 6);
        push_n(r_done(1'b0), 1);
        push_n(r_idle(), 1);
        tick("abort_flush");
        start_i = 1'b0;
        tick_n("abort_flush", 38);
        abort_i = 1'b1;
        tick_n("abort_flush", 2);
        abort_i = 1'b0;
        tick_n("abort_flush", 3);

        start_i = 1'b1; abort_i = 1'b1; input_mask_i = 8'hFF;
        push_n(r_idle(), 3);
        tick("start_abort");
        start_i = 1'b0; abort_i = 1'b0;
        tick_n("start_abort", 2);

        // synchronous reset mid-LOAD, then a fresh full run
        start_i = 1'b1; input_mask_i = 8'h0F;
        push_n(r_load(8'h0F), 2);
        push_n(r_idle(), 2);
        tick("rst_load");
        start_i = 1'b0;
        tick("rst_load");
        rst_i = 1'b1;
        tick("rst_load");
        rst_i = 1'b0;
        tick("rst_load");
        start_i = 1'b1; input_mask_i = 8'h81;
        push_n(r_load(8'h81), 4);
        push_sweeps(1);
        push_n(r_flush(), 6);
        push_n(r_done(1'b0), 1);
        push_n(r_idle(), 1);
        busy_cnt = 0;
        tick("rerun");
        start_i = 1'b0;
        tick_n("rerun", 43);
        chk("busy_window", 32'(busy_cnt), 32'd42);

`ifdef BRAID_SCHED_RECIRC_EN
        start_i = 1'b1; input_mask_i = 8'h77; passes_i = 2'd2;
        push_n(r_load(8'h77), 4);
        push_sweeps(3);
        push_n(r_flush(), 6);
        push_n(r_done(1'b0), 1);
        push_n(r_idle(), 1);
        busy_cnt = 0;
        tick("recirc");
        start_i = 1'b0; passes_i = 2'd0;
        tick_n("recirc", 107);
        chk("recirc_busy", 32'(busy_cnt), 32'd106);
`endif

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
